// File: rtl/hb_period_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hb_period_meas_pkg
// Purpose : Shared FSM state encoding, QF fixed-point constants and a
//           saturation helper for the heartbeat period front-end.
// Revision: 1.0 - initial release
// ============================================================================
package hb_period_meas_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MEAS = 2'd1;
  localparam state_t S_REQ  = 2'd2;
  localparam state_t S_WAIT = 2'd3;

  // QF helper constants for the default 32-bit word with 16 fractional bits
  localparam int            QF_W   = 32;
  localparam int            QF_F   = 16;
  localparam logic [31:0]   QF_ONE = 32'h0001_0000;
  localparam logic [31:0]   QF_MAX = 32'h7FFF_FFFF;

  // Largest positive value of a signed word of width w
  function automatic logic [63:0] qf_max_of(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Unsigned clamp of v to lim
  function automatic logic [63:0] qf_sat(input logic [63:0] v, input logic [63:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hb_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : hb_edge_sync
// Purpose : Two-flop synchroniser for the asynchronous heartbeat followed by
//           a registered rising-edge detector producing a one-cycle pulse.
// Revision: 1.0 - initial release
// ============================================================================
module hb_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic hb_async,
  output logic hb_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  // Next-state: shift the heartbeat through the synchroniser, flag a 0->1 step
  always_comb begin
    sync1_d = hb_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  // Synchroniser, history and pulse flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign hb_edge = pulse_q;

endmodule
`default_nettype wire

// File: rtl/hb_period_meas.sv
`default_nettype none
// ============================================================================
// Module  : hb_period_meas
// Purpose : Measures the clk-cycle interval between heartbeat rising edges,
//           converts it to signed QF, runs the reciprocal start/done
//           handshake and captures the returned frequency.
// Options : HB_AVG_EN - moving average over 2^AVG_LOG2 samples before
//           publication (ring logic absent when undefined).
// Revision: 1.0 - initial release
// ============================================================================
module hb_period_meas
  import hb_period_meas_pkg::*;
#(
  parameter int W        = 32,
  parameter int F        = 16,
  parameter int CNT_W    = 24,
  parameter int SCALE_SH = 10,
  parameter int AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         hb_in,
  output logic         recip_start,
  output logic [W-1:0] recip_x,
  input  logic         recip_done,
  input  logic [W-1:0] recip_y,
  input  logic         recip_invalid,
  output logic [W-1:0] freq_q,
  output logic         freq_valid,
  output logic         freq_err,
  output logic         stall,
  output logic         overrun
);

  if (SCALE_SH > F || AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_cfg_check
    $error("hb_period_meas: need SCALE_SH <= F and 1 <= AVG_LOG2 <= 8");
  end

  localparam int               c_qf_sh   = (SCALE_SH <= F) ? (F - SCALE_SH) : 0;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [63:0]      c_x_max   = qf_max_of(W);

  logic             hb_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             stall_q, stall_d;
  logic             sample_vld;
  logic [CNT_W-1:0] sample;
  logic             pub_vld;
  logic [CNT_W-1:0] pub_val;
  logic [W-1:0]     x_new;

  hb_edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .hb_async (hb_in),
    .hb_edge  (hb_edge)
  );

  // Interval counter: counts between edges, saturates into stall; the first
  // edge (or the one after a stall) only arms, later edges emit samples
  always_comb begin
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    stall_d    = stall_q;
    sample_vld = 1'b0;
    sample     = cnt_q + 1'b1;
    if (!enable) begin
      cnt_d   = '0;
      armed_d = 1'b0;
      stall_d = 1'b0;
    end else if (hb_edge) begin
      cnt_d = '0;
      if (stall_q) begin
        stall_d = 1'b0;
        armed_d = 1'b1;
      end else if (cnt_q == c_cnt_max) begin
        stall_d = 1'b1;
        armed_d = 1'b0;
      end else begin
        sample_vld = armed_q;
        armed_d    = 1'b1;
      end
    end else if (cnt_q == c_cnt_max) begin
      stall_d = 1'b1;
      armed_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Interval counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      stall_q <= stall_d;
    end
  end

`ifdef HB_AVG_EN
  localparam int                c_depth = 1 << AVG_LOG2;
  localparam int                c_sum_w = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] c_full  = {1'b1, {AVG_LOG2{1'b0}}};

  logic [CNT_W-1:0]    ring_q [c_depth];
  logic [CNT_W-1:0]    ring_d [c_depth];
  logic [AVG_LOG2-1:0] wr_q, wr_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [c_sum_w-1:0]  sum_q, sum_d;

  // Moving-average ring: running sum replaces the oldest entry; publish only
  // once every slot holds a real sample; flush while stalled or disabled
  always_comb begin
    ring_d  = ring_q;
    wr_d    = wr_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    pub_vld = 1'b0;
    if (!enable || stall_q) begin
      for (int i = 0; i < c_depth; i++) ring_d[i] = '0;
      wr_d   = '0;
      fill_d = '0;
      sum_d  = '0;
    end else if (sample_vld) begin
      sum_d        = sum_q + {{AVG_LOG2{1'b0}}, sample} - {{AVG_LOG2{1'b0}}, ring_q[wr_q]};
      ring_d[wr_q] = sample;
      wr_d         = wr_q + 1'b1;
      if (fill_q != c_full) fill_d = fill_q + 1'b1;
      pub_vld      = (fill_d == c_full);
    end
    pub_val = sum_d[c_sum_w-1:AVG_LOG2];
  end

  // Averaging ring state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) ring_q[i] <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else begin
      ring_q <= ring_d;
      wr_q   <= wr_d;
      fill_q <= fill_d;
      sum_q  <= sum_d;
    end
  end
`else
  assign pub_vld = sample_vld;
  assign pub_val = sample;
`endif

  // Cycles -> QF: one unit is 2^SCALE_SH cycles, clamped to the signed maximum
  assign x_new = W'(qf_sat(64'(pub_val) << c_qf_sh, c_x_max));

  state_t       state_q, state_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_x_q, pend_x_d;
  logic         overrun_q, overrun_d;
  logic         recip_start_q, recip_start_d;
  logic [W-1:0] recip_x_q, recip_x_d;
  logic [W-1:0] freq_d;
  logic         freq_valid_q, freq_valid_d;
  logic         freq_err_q, freq_err_d;
  logic         pend_take;

  // Request FSM and pending slot; recip_x loads on entry to S_REQ so it is
  // already stable in the start cycle and holds until the next request
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_x_d      = pend_x_q;
    overrun_d     = overrun_q;
    recip_start_d = 1'b0;
    recip_x_d     = recip_x_q;
    freq_d        = freq_q;
    freq_valid_d  = 1'b0;
    freq_err_d    = freq_err_q;
    pend_take     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && hb_edge) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pend_q) begin
          state_d       = S_REQ;
          recip_x_d     = pend_x_q;
          recip_start_d = 1'b1;
          pend_take     = 1'b1;
        end
      end
      S_REQ: begin
        state_d = enable ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (recip_done) begin
          freq_d       = recip_y;
          freq_err_d   = recip_invalid;
          freq_valid_d = 1'b1;
          state_d      = enable ? S_MEAS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pend_take) pend_d = 1'b0;
    if (pub_vld) begin
      if (pend_q && !pend_take) overrun_d = 1'b1;
      pend_d   = 1'b1;
      pend_x_d = x_new;
    end
  end

  // FSM, pending slot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      pend_x_q      <= '0;
      overrun_q     <= 1'b0;
      recip_start_q <= 1'b0;
      recip_x_q     <= '0;
      freq_q        <= '0;
      freq_valid_q  <= 1'b0;
      freq_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_x_q      <= pend_x_d;
      overrun_q     <= overrun_d;
      recip_start_q <= recip_start_d;
      recip_x_q     <= recip_x_d;
      freq_q        <= freq_d;
      freq_valid_q  <= freq_valid_d;
      freq_err_q    <= freq_err_d;
    end
  end

  assign recip_start = recip_start_q;
  assign recip_x     = recip_x_q;
  assign freq_valid  = freq_valid_q;
  assign freq_err    = freq_err_q;
  assign stall       = stall_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_hb_period_meas.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_hb_period_meas
// Purpose : Directed self-checking bench for hb_period_meas (CNT_W = 12)
//           with a behavioural reciprocal stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hb_period_meas;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         hb_in;
  logic         recip_start;
  logic [W-1:0] recip_x;
  logic         recip_done;
  logic [W-1:0] recip_y;
  logic         recip_invalid;
  logic [W-1:0] freq_q;
  logic         freq_valid;
  logic         freq_err;
  logic         stall;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation state (written only by the monitor)
  int           n_start  = 0;
  int           n_fv     = 0;
  int           x_change = 0;
  logic [W-1:0] last_x   = '0;
  logic         win      = 1'b0;
  logic [W-1:0] win_x    = '0;

  // Reciprocal model settings (written only by the main sequence)
  int           resp_delay = 5;
  logic [W-1:0] resp_y     = 32'd65536;
  logic         resp_inv   = 1'b0;

  hb_period_meas #(
    .W        (32),
    .F        (16),
    .CNT_W    (12),
    .SCALE_SH (10),
    .AVG_LOG2 (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .hb_in         (hb_in),
    .recip_start   (recip_start),
    .recip_x       (recip_x),
    .recip_done    (recip_done),
    .recip_y       (recip_y),
    .recip_invalid (recip_invalid),
    .freq_q        (freq_q),
    .freq_valid    (freq_valid),
    .freq_err      (freq_err),
    .stall         (stall),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: count requests and results, track recip_x across each request window
  always @(negedge clk) begin
    if (recip_start) begin
      n_start <= n_start + 1;
      last_x  <= recip_x;
    end
    if (freq_valid) n_fv <= n_fv + 1;
    if (!rst_n) begin
      win <= 1'b0;
    end else if (recip_start) begin
      win   <= 1'b1;
      win_x <= recip_x;
    end else if (win) begin
      if (recip_x !== win_x) x_change <= x_change + 1;
      if (recip_done) win <= 1'b0;
    end
  end

  // Reciprocal stage model: answers each start after resp_delay cycles
  initial begin
    recip_done    = 1'b0;
    recip_y       = '0;
    recip_invalid = 1'b0;
    forever begin
      @(negedge clk);
      if (recip_start && rst_n) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        recip_done    = 1'b1;
        recip_y       = resp_y;
        recip_invalid = resp_inv;
        @(posedge clk);
        #1;
        recip_done    = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n heartbeat rises spaced period cycles apart, high for 4 cycles each
  task automatic hb_pulses(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      hb_in = 1'b1;
      tick(4);
      hb_in = 1'b0;
      tick(period - 4);
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(2);
  endtask

  task automatic wait_fv(input int target, input int budget);
    int k;
    k = 0;
    while (n_fv < target && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (n_fv < target) begin
      n_fail++;
      $display("FAIL wait_freq_valid: count %0d, required %0d", n_fv, target);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    hb_in  = 1'b0;
    rst_n  = 1'b1;
    #3;
    rst_n  = 1'b0;
    tick(3);
    n_checks++; if (recip_start !== 1'b0) begin n_fail++; $display("FAIL reset_recip_start: got %b, required 0", recip_start); end
    n_checks++; if (recip_x !== 32'd0) begin n_fail++; $display("FAIL reset_recip_x: got %0d, required 0", recip_x); end
    n_checks++; if (freq_q !== 32'd0) begin n_fail++; $display("FAIL reset_freq_q: got %0d, required 0", freq_q); end
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_freq_valid: got %b, required 0", freq_valid); end
    n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL reset_freq_err: got %b, required 0", freq_err); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    rst_n = 1'b1;
    tick(2);
  endtask

`ifdef HB_AVG_EN
  task automatic test_avg();
    int s0;
    rearm();
    resp_delay = 5;
    resp_y     = 32'd65536;
    resp_inv   = 1'b0;
    s0 = n_start;
    hb_pulses(2, 1024);
    hb_pulses(2, 2048);
    n_checks++; if (n_start !== s0) begin n_fail++; $display("FAIL avg_no_early_req: got %0d requests, required 0", n_start - s0); end
    hb_pulses(1, 40);
    n_checks++; if (n_start !== s0 + 1) begin n_fail++; $display("FAIL avg_req_count: got %0d, required 1", n_start - s0); end
    n_checks++; if (last_x !== 32'd98304) begin n_fail++; $display("FAIL avg_recip_x: got %0d, required 98304", last_x); end
  endtask
`else
  task automatic test_basic();
    int s0, f0, c0;
    rearm();
    resp_delay = 5;
    resp_y     = 32'd65536;
    resp_inv   = 1'b0;
    s0 = n_start; f0 = n_fv; c0 = x_change;
    hb_pulses(5, 1024);
    tick(30);
    n_checks++; if (n_start !== s0 + 4) begin n_fail++; $display("FAIL basic_req_count: got %0d, required 4", n_start - s0); end
    n_checks++; if (n_fv !== f0 + 4) begin n_fail++; $display("FAIL basic_freq_valid_count: got %0d, required 4", n_fv - f0); end
    n_checks++; if (last_x !== 32'd65536) begin n_fail++; $display("FAIL basic_recip_x: got %0d, required 65536", last_x); end
    n_checks++; if (freq_q !== 32'd65536) begin n_fail++; $display("FAIL basic_freq_q: got %0d, required 65536", freq_q); end
    n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL basic_freq_err: got %b, required 0", freq_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b, required 0", overrun); end
    n_checks++; if (x_change !== c0) begin n_fail++; $display("FAIL basic_x_stable: got %0d changes, required 0", x_change - c0); end
  endtask

  task automatic test_stall();
    int s0;
    s0 = n_start;
    tick(2000);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b, required 0", stall); end
    tick(3000);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b, required 1", stall); end
    n_checks++; if (n_start !== s0) begin n_fail++; $display("FAIL stall_no_req: got %0d, required 0", n_start - s0); end
    hb_pulses(1, 1024);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_cleared: got %b, required 0", stall); end
    n_checks++; if (n_start !== s0) begin n_fail++; $display("FAIL stall_clear_no_req: got %0d, required 0", n_start - s0); end
    hb_pulses(1, 40);
    n_checks++; if (n_start !== s0 + 1) begin n_fail++; $display("FAIL stall_rearm_req: got %0d, required 1", n_start - s0); end
    n_checks++; if (last_x !== 32'd65536) begin n_fail++; $display("FAIL stall_rearm_x: got %0d, required 65536", last_x); end
  endtask

  task automatic test_2048();
    int s0;
    rearm();
    resp_delay = 5;
    s0 = n_start;
    hb_pulses(3, 2048);
    tick(30);
    n_checks++; if (n_start !== s0 + 2) begin n_fail++; $display("FAIL p2048_req_count: got %0d, required 2", n_start - s0); end
    n_checks++; if (last_x !== 32'd131072) begin n_fail++; $display("FAIL p2048_recip_x: got %0d, required 131072", last_x); end
  endtask

  task automatic test_overrun();
    int s0, f0, c0;
    rearm();
    resp_delay = 3000;
    resp_y     = 32'd65536;
    resp_inv   = 1'b0;
    s0 = n_start; f0 = n_fv; c0 = x_change;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_before: got %b, required 0", overrun); end
    hb_pulses(1, 1024);
    hb_pulses(1, 1000);
    hb_pulses(1, 1100);
    hb_pulses(1, 40);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    wait_fv(f0 + 2, 8000);
    n_checks++; if (n_start !== s0 + 2) begin n_fail++; $display("FAIL overrun_req_count: got %0d, required 2", n_start - s0); end
    n_checks++; if (last_x !== 32'd70400) begin n_fail++; $display("FAIL overrun_latest_x: got %0d, required 70400", last_x); end
    n_checks++; if (x_change !== c0) begin n_fail++; $display("FAIL overrun_x_stable: got %0d changes, required 0", x_change - c0); end
    rearm();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
  endtask

  task automatic test_invalid();
    int f0;
    rearm();
    resp_delay = 2;
    resp_y     = 32'h1234_5678;
    resp_inv   = 1'b1;
    f0 = n_fv;
    hb_pulses(2, 1024);
    n_checks++; if (n_fv !== f0 + 1) begin n_fail++; $display("FAIL invalid_fv_count: got %0d, required 1", n_fv - f0); end
    n_checks++; if (freq_q !== 32'h1234_5678) begin n_fail++; $display("FAIL invalid_freq_q: got %h, required 12345678", freq_q); end
    n_checks++; if (freq_err !== 1'b1) begin n_fail++; $display("FAIL invalid_freq_err: got %b, required 1", freq_err); end
  endtask
`endif

  task automatic test_reset_in_wait();
    int f0;
    rearm();
    resp_delay = 200;
    resp_y     = 32'd77;
    resp_inv   = 1'b0;
    hb_pulses(1, 1024);
    hb_in = 1'b1;
    tick(10);
    hb_in = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (recip_start !== 1'b0) begin n_fail++; $display("FAIL rstw_recip_start: got %b, required 0", recip_start); end
    n_checks++; if (recip_x !== 32'd0) begin n_fail++; $display("FAIL rstw_recip_x: got %0d, required 0", recip_x); end
    n_checks++; if (freq_q !== 32'd0) begin n_fail++; $display("FAIL rstw_freq_q: got %0d, required 0", freq_q); end
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_freq_valid: got %b, required 0", freq_valid); end
    n_checks++; if (freq_err !== 1'b0) begin n_fail++; $display("FAIL rstw_freq_err: got %b, required 0", freq_err); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstw_stall: got %b, required 0", stall); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstw_overrun: got %b, required 0", overrun); end
    tick(2);
    f0 = n_fv;
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(250);
    n_checks++; if (n_fv !== f0) begin n_fail++; $display("FAIL rstw_late_done_fv: got %0d pulses, required 0", n_fv - f0); end
    n_checks++; if (freq_q !== 32'd0) begin n_fail++; $display("FAIL rstw_late_done_freq_q: got %0d, required 0", freq_q); end
  endtask

  initial begin
    test_reset();
`ifdef HB_AVG_EN
    test_avg();
`else
    test_basic();
    test_stall();
    test_2048();
    test_overrun();
    test_invalid();
`endif
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
